// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
// Response arrives RSP_LATENCY cycles after the accepting cycle.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef logic reqId_t;

  localparam int RSP_LATENCY = 2;

  function automatic reqId_t grantToId(input logic [1:0] grant);
    return grant[1];
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester, response and memory-side signals of mem_arbiter.
// The arbiter uses the slave modport; requesters plus the memory model sit on master.
interface mem_arbiter_if #(
  parameter int DATA_W = 32
);

  logic              req0_valid_i;
  logic              req0_write_i;
  logic [DATA_W-1:0] req0_addr_i;
  logic [DATA_W-1:0] req0_wdata_i;
  logic              req0_ready_o;
  logic              rsp0_valid_o;
  logic [DATA_W-1:0] rsp0_rdata_o;
  logic              rsp0_err_o;

  logic              req1_valid_i;
  logic              req1_write_i;
  logic [DATA_W-1:0] req1_addr_i;
  logic [DATA_W-1:0] req1_wdata_i;
  logic              req1_ready_o;
  logic              rsp1_valid_o;
  logic [DATA_W-1:0] rsp1_rdata_o;
  logic              rsp1_err_o;

  logic [DATA_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_read_o;
  logic              mem_write_o;
  logic [DATA_W-1:0] mem_rdata_i;

  modport slave (
    input  req0_valid_i, req0_write_i, req0_addr_i, req0_wdata_i,
    input  req1_valid_i, req1_write_i, req1_addr_i, req1_wdata_i,
    input  mem_rdata_i,
    output req0_ready_o, rsp0_valid_o, rsp0_rdata_o, rsp0_err_o,
    output req1_ready_o, rsp1_valid_o, rsp1_rdata_o, rsp1_err_o,
    output mem_addr_o, mem_wdata_o, mem_read_o, mem_write_o
  );

  modport master (
    output req0_valid_i, req0_write_i, req0_addr_i, req0_wdata_i,
    output req1_valid_i, req1_write_i, req1_addr_i, req1_wdata_i,
    output mem_rdata_i,
    input  req0_ready_o, rsp0_valid_o, rsp0_rdata_o, rsp0_err_o,
    input  req1_ready_o, rsp1_valid_o, rsp1_rdata_o, rsp1_err_o,
    input  mem_addr_o, mem_wdata_o, mem_read_o, mem_write_o
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Two-way winner select, purely combinational: ptr breaks ties when both request.
// nextPtr points away from the winner so the other side is preferred next time.
module mem_arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] valid,
  input  reqId_t     ptr,
  output logic [1:0] grant,
  output reqId_t     nextPtr
);

  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = ptr ? 2'b10 : 2'b01;
    end
  end

  assign nextPtr = (grant == 2'b00) ? ptr : ~grantToId(grant);

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester single-port memory arbiter: accept T, strobe T+1, response T+2, next accept T+3.
// Losers simply see ready low and hold valid; MEM_ARBITER_RR_EN selects round-robin over fixed priority.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  mem_arbiter_if.slave bus
);

  state_t            state;
  state_t            stateNext;
  logic [1:0]        reqValid;
  logic [1:0]        grant;
  reqId_t            ptr;
  reqId_t            nextPtr;
  logic              accept;

  logic              selWrite;
  logic [DATA_W-1:0] selAddr;
  logic [DATA_W-1:0] selWdata;

  logic              latWrite;
  logic              latErr;
  reqId_t            latId;
  logic [DATA_W-1:0] latAddr;
  logic [DATA_W-1:0] latWdata;
  logic [DATA_W-1:0] rspData;

  assign reqValid = {bus.req1_valid_i, bus.req0_valid_i};
  assign accept   = (state == IDLE) && (reqValid != 2'b00);

`ifdef MEM_ARBITER_RR_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr <= 1'b0;
    end else if (accept) begin
      ptr <= nextPtr;
    end
  end
`else
  reqId_t unusedNextPtr;
  assign ptr           = 1'b0;
  assign unusedNextPtr = nextPtr;
`endif

  mem_arb_pick uPick (
    .valid   (reqValid),
    .ptr     (ptr),
    .grant   (grant),
    .nextPtr (nextPtr)
  );

  always_comb begin
    selWrite = bus.req0_write_i;
    selAddr  = bus.req0_addr_i;
    selWdata = bus.req0_wdata_i;
    if (grant[1]) begin
      selWrite = bus.req1_write_i;
      selAddr  = bus.req1_addr_i;
      selWdata = bus.req1_wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Range errors are resolved at acceptance so ISSUE only has to gate strobes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      latWrite <= 1'b0;
      latErr   <= 1'b0;
      latId    <= 1'b0;
      latAddr  <= '0;
      latWdata <= '0;
      rspData  <= '0;
    end else begin
      if (accept) begin
        latWrite <= selWrite;
        latErr   <= (selAddr >= DATA_W'(DEPTH));
        latId    <= grantToId(grant);
        latAddr  <= selAddr;
        latWdata <= selWdata;
      end
      if (state == ISSUE) begin
        rspData <= (!latWrite && !latErr) ? bus.mem_rdata_i : '0;
      end
    end
  end

  always_comb begin
    stateNext        = state;
    bus.req0_ready_o = 1'b0;
    bus.req1_ready_o = 1'b0;
    bus.rsp0_valid_o = 1'b0;
    bus.rsp0_rdata_o = '0;
    bus.rsp0_err_o   = 1'b0;
    bus.rsp1_valid_o = 1'b0;
    bus.rsp1_rdata_o = '0;
    bus.rsp1_err_o   = 1'b0;
    bus.mem_addr_o   = '0;
    bus.mem_wdata_o  = '0;
    bus.mem_read_o   = 1'b0;
    bus.mem_write_o  = 1'b0;
    case (state)
      IDLE: begin
        bus.req0_ready_o = grant[0];
        bus.req1_ready_o = grant[1];
        if (accept) begin
          stateNext = ISSUE;
        end
      end
      ISSUE: begin
        bus.mem_addr_o  = latAddr;
        bus.mem_wdata_o = latWdata;
        bus.mem_read_o  = !latErr && !latWrite;
        bus.mem_write_o = !latErr && latWrite;
        stateNext       = DONE;
      end
      DONE: begin
        if (latId == 1'b0) begin
          bus.rsp0_valid_o = 1'b1;
          bus.rsp0_rdata_o = rspData;
          bus.rsp0_err_o   = latErr;
        end else begin
          bus.rsp1_valid_o = 1'b1;
          bus.rsp1_rdata_o = rspData;
          bus.rsp1_err_o   = latErr;
        end
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  assert property (@(posedge clk_i) !(bus.mem_read_o && bus.mem_write_o));
  assert property (@(posedge clk_i) !(bus.req0_ready_o && bus.req1_ready_o));
  assert property (@(posedge clk_i) !(bus.rsp0_valid_o && bus.rsp1_valid_o));

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed transaction table, corner sequences, and a randomized
// run checked against a transaction-level model (accept time, memory image, winner rule).
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int DEPTH  = 8;
  localparam int DATA_W = 32;
  localparam int AW     = 3;
`ifdef MEM_ARBITER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk_i = 1'b0;
  logic rst_i;

  mem_arbiter_if #(.DATA_W(DATA_W)) bus ();

  mem_arbiter #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  // Memory model: only the low address bits decode, so a strobe escaping on a bad address is visible.
  logic [DATA_W-1:0] envMem [DEPTH];
  assign bus.mem_rdata_i = bus.mem_read_o ? envMem[bus.mem_addr_o[AW-1:0]] : 32'hA5A5_5A5A;
  always @(posedge clk_i) begin
    if (bus.mem_write_o) envMem[bus.mem_addr_o[AW-1:0]] <= bus.mem_wdata_o;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chkBit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic driveReq(input int n, input logic v, input logic wr,
                          input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] d);
    if (n == 0) begin
      bus.req0_valid_i = v; bus.req0_write_i = wr; bus.req0_addr_i = a; bus.req0_wdata_i = d;
    end else begin
      bus.req1_valid_i = v; bus.req1_write_i = wr; bus.req1_addr_i = a; bus.req1_wdata_i = d;
    end
  endtask

  task automatic clearReqs();
    driveReq(0, 1'b0, 1'b0, '0, '0);
    driveReq(1, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic doReset();
    rst_i = 1'b1;
    clearReqs();
    @(posedge clk_i);
    @(posedge clk_i);
    #1 rst_i = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    chkBit({tag, " ready0"}, bus.req0_ready_o, 1'b0);
    chkBit({tag, " ready1"}, bus.req1_ready_o, 1'b0);
    chkBit({tag, " rsp0_valid"}, bus.rsp0_valid_o, 1'b0);
    chkBit({tag, " rsp1_valid"}, bus.rsp1_valid_o, 1'b0);
    chk({tag, " rsp0_rdata"}, bus.rsp0_rdata_o, '0);
    chk({tag, " rsp1_rdata"}, bus.rsp1_rdata_o, '0);
    chkBit({tag, " rsp0_err"}, bus.rsp0_err_o, 1'b0);
    chkBit({tag, " rsp1_err"}, bus.rsp1_err_o, 1'b0);
    chk({tag, " mem_addr"}, bus.mem_addr_o, '0);
    chk({tag, " mem_wdata"}, bus.mem_wdata_o, '0);
    chkBit({tag, " mem_read"}, bus.mem_read_o, 1'b0);
    chkBit({tag, " mem_write"}, bus.mem_write_o, 1'b0);
  endtask

  typedef struct {
    logic [1:0]        vld;
    logic              wr;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [1:0]        expGnt;
    logic              expRd;
    logic              expWr;
    logic [DATA_W-1:0] expRdata;
    logic              expErr;
  } vec_t;

  vec_t vecs [8];

  // One full transaction, entered and left one time unit after a rising edge.
  task automatic runVec(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("vec%0d", idx);
    driveReq(0, v.vld[0], v.wr, v.addr, v.wdata);
    driveReq(1, v.vld[1], v.wr, v.addr, v.wdata);
    #1;
    chk({tag, " ready"}, 32'({bus.req1_ready_o, bus.req0_ready_o}), 32'(v.expGnt));
    chkBit({tag, " T strobe"}, bus.mem_read_o | bus.mem_write_o, 1'b0);
    @(posedge clk_i); #1;
    clearReqs();
    #1;
    chkBit({tag, " mem_read"}, bus.mem_read_o, v.expRd);
    chkBit({tag, " mem_write"}, bus.mem_write_o, v.expWr);
    if (v.expRd || v.expWr) chk({tag, " mem_addr"}, bus.mem_addr_o, v.addr);
    if (v.expWr) chk({tag, " mem_wdata"}, bus.mem_wdata_o, v.wdata);
    chk({tag, " early rsp"}, 32'({bus.rsp1_valid_o, bus.rsp0_valid_o}), 32'd0);
    @(posedge clk_i); #2;
    chk({tag, " rsp_valid"}, 32'({bus.rsp1_valid_o, bus.rsp0_valid_o}), 32'(v.expGnt));
    chk({tag, " rsp_rdata"}, v.expGnt[1] ? bus.rsp1_rdata_o : bus.rsp0_rdata_o, v.expRdata);
    chkBit({tag, " rsp_err"}, v.expGnt[1] ? bus.rsp1_err_o : bus.rsp0_err_o, v.expErr);
    chkBit({tag, " T+2 strobe"}, bus.mem_read_o | bus.mem_write_o, 1'b0);
    @(posedge clk_i); #1;
  endtask

  // Transaction-level model state for the randomized run.
  logic [DATA_W-1:0] refMem [DEPTH];
  bit                pend [2];
  logic              pWr [2];
  logic [DATA_W-1:0] pAddr [2];
  logic [DATA_W-1:0] pWd [2];
  bit                haveTxn;
  int                accCyc, accId, nextFree, lastWin, win;
  logic              accWr, accErr;
  logic [DATA_W-1:0] accAddr, accWd, accRd;
  logic [1:0]        expG;
  bit                strobeNow, rspNow;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{2'b01, 1'b0, 32'd3, 32'd0,          2'b01, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0};
    vecs[1] = '{2'b10, 1'b1, 32'd5, 32'h12345678,   2'b10, 1'b0, 1'b1, 32'd0,        1'b0};
    vecs[2] = '{2'b10, 1'b0, 32'd5, 32'd0,          2'b10, 1'b1, 1'b0, 32'h12345678, 1'b0};
    vecs[3] = '{2'b01, 1'b0, 32'd8, 32'd0,          2'b01, 1'b0, 1'b0, 32'd0,        1'b1};
    vecs[4] = '{2'b01, 1'b1, 32'd7, 32'hCAFEF00D,   2'b01, 1'b0, 1'b1, 32'd0,        1'b0};
    vecs[5] = '{2'b10, 1'b0, 32'd7, 32'd0,          2'b10, 1'b1, 1'b0, 32'hCAFEF00D, 1'b0};
    vecs[6] = '{2'b10, 1'b1, 32'hFFFFFFFF, 32'h0BADC0DE, 2'b10, 1'b0, 1'b0, 32'd0,   1'b1};
    vecs[7] = '{2'b01, 1'b0, 32'd7, 32'd0,          2'b01, 1'b1, 1'b0, 32'hCAFEF00D, 1'b0};

    for (int i = 0; i < DEPTH; i++) envMem[i] = 32'h1000_0000 + i;
    envMem[3] = 32'hDEADBEEF;

    doReset();
    #1 checkAllZero("reset");
    @(posedge clk_i); #1;

    for (int i = 0; i < 8; i++) runVec(i, vecs[i]);

    // Both requesters held valid across four transactions.
    doReset();
    driveReq(0, 1'b1, 1'b0, 32'd3, 32'd0);
    driveReq(1, 1'b1, 1'b0, 32'd5, 32'd0);
    for (int k = 0; k < 4; k++) begin
      expG = (RR && (k % 2 == 1)) ? 2'b10 : 2'b01;
      #1;
      chk($sformatf("both grant%0d", k), 32'({bus.req1_ready_o, bus.req0_ready_o}), 32'(expG));
      @(posedge clk_i); #2;
      chk($sformatf("both busy ready%0d", k), 32'({bus.req1_ready_o, bus.req0_ready_o}), 32'd0);
      @(posedge clk_i); #2;
      chk($sformatf("both rsp%0d", k), 32'({bus.rsp1_valid_o, bus.rsp0_valid_o}), 32'(expG));
      chk($sformatf("both rdata%0d", k), expG[1] ? bus.rsp1_rdata_o : bus.rsp0_rdata_o,
          expG[1] ? 32'h12345678 : 32'hDEADBEEF);
      @(posedge clk_i); #1;
    end
    clearReqs();

    // Reset landing on the ISSUE cycle of a read.
    driveReq(0, 1'b1, 1'b0, 32'd3, 32'd0);
    #1 chkBit("rstIssue ready0", bus.req0_ready_o, 1'b1);
    @(posedge clk_i); #1;
    clearReqs();
    rst_i = 1'b1;
    #1 chkBit("rstIssue strobe", bus.mem_read_o, 1'b1);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    #1 checkAllZero("rstIssue");
    @(posedge clk_i); #2;
    chkBit("rstIssue late rsp0", bus.rsp0_valid_o, 1'b0);
    chkBit("rstIssue late read", bus.mem_read_o, 1'b0);
    @(posedge clk_i); #1;
    driveReq(0, 1'b1, 1'b0, 32'd1, 32'd0);
    driveReq(1, 1'b1, 1'b0, 32'd2, 32'd0);
    #1 chk("rstIssue regrant", 32'({bus.req1_ready_o, bus.req0_ready_o}), 32'd1);
    @(posedge clk_i); #1;
    clearReqs();
    repeat (2) @(posedge clk_i);
    #1;

    // Randomized traffic against the transaction-level model.
    doReset();
    for (int i = 0; i < DEPTH; i++) begin
      envMem[i] = $urandom;
      refMem[i] = envMem[i];
    end
    haveTxn = 0; nextFree = 0; lastWin = 1; accCyc = 0; accId = 0;
    accWr = 0; accErr = 0; accAddr = '0; accWd = '0; accRd = '0;
    for (int n = 0; n < 2; n++) begin
      pend[n] = 0; pWr[n] = 0; pAddr[n] = '0; pWd[n] = '0;
    end
    for (int c = 0; c < 1500; c++) begin
      for (int n = 0; n < 2; n++) begin
        if (!pend[n] && $urandom_range(0, 2) != 0) begin
          pend[n]  = 1;
          pWr[n]   = 1'($urandom_range(0, 1));
          pAddr[n] = $urandom_range(0, DEPTH + 1);
          pWd[n]   = $urandom;
        end else if (pend[n] && $urandom_range(0, 15) == 0) begin
          pend[n] = 0;
        end
        driveReq(n, pend[n], pWr[n], pAddr[n], pWd[n]);
      end
      #1;
      win = -1;
      if (c >= nextFree && (pend[0] || pend[1])) begin
        if (pend[0] && pend[1]) win = RR ? 1 - lastWin : 0;
        else win = pend[0] ? 0 : 1;
      end
      chkBit("rnd ready0", bus.req0_ready_o, win == 0);
      chkBit("rnd ready1", bus.req1_ready_o, win == 1);
      strobeNow = haveTxn && (c == accCyc + 1) && !accErr;
      chkBit("rnd mem_read", bus.mem_read_o, strobeNow && !accWr);
      chkBit("rnd mem_write", bus.mem_write_o, strobeNow && accWr);
      if (strobeNow) chk("rnd mem_addr", bus.mem_addr_o, accAddr);
      if (strobeNow && accWr) chk("rnd mem_wdata", bus.mem_wdata_o, accWd);
      rspNow = haveTxn && (c == accCyc + RSP_LATENCY);
      chkBit("rnd rsp0_valid", bus.rsp0_valid_o, rspNow && accId == 0);
      chkBit("rnd rsp1_valid", bus.rsp1_valid_o, rspNow && accId == 1);
      if (rspNow) begin
        chk("rnd rsp_rdata", (accId == 1) ? bus.rsp1_rdata_o : bus.rsp0_rdata_o, accRd);
        chkBit("rnd rsp_err", (accId == 1) ? bus.rsp1_err_o : bus.rsp0_err_o, accErr);
      end
      if (win >= 0) begin
        haveTxn = 1;
        accCyc  = c;
        accId   = win;
        accWr   = pWr[win];
        accAddr = pAddr[win];
        accWd   = pWd[win];
        accErr  = (accAddr >= DEPTH);
        accRd   = '0;
        if (!accErr) begin
          if (accWr) refMem[accAddr[AW-1:0]] = accWd;
          else accRd = refMem[accAddr[AW-1:0]];
        end
        nextFree = c + RSP_LATENCY + 1;
        lastWin  = win;
        pend[win] = 0;
      end
      @(posedge clk_i); #1;
    end
    clearReqs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 8: number of memory words; valid word addresses are 0..DEPTH-1.
REQ-002 SHALL have parameter DATA_W, default 32: data and address width.
REQ-003 SHALL have port clk_i  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i  in  1  reset, synchronous, active-high.
REQ-005 SHALL have, for each requester n in {0,1}, port reqN_valid_i  in  1  request pending.
REQ-006 SHALL have reqN_write_i  in  1  1 = write, 0 = read.
REQ-007 SHALL have reqN_addr_i  in  DATA_W  word address.
REQ-008 SHALL have reqN_wdata_i  in  DATA_W  write data.
REQ-009 SHALL have reqN_ready_o  out  1  request accepted this cycle.
REQ-010 SHALL have rspN_valid_o  out  1  one-cycle completion pulse.
REQ-011 SHALL have rspN_rdata_o  out  DATA_W  read data, meaningful only while rspN_valid_o is high.
REQ-012 SHALL have rspN_err_o  out  1  address-range error, qualified by rspN_valid_o.
REQ-013 SHALL have mem_addr_o and mem_wdata_o  out  DATA_W  address and data to the memory.
REQ-014 SHALL have mem_read_o and mem_write_o  out  1  memory strobes.
REQ-015 SHALL have mem_rdata_i  in  DATA_W  memory read data, valid by the end of the cycle in which mem_read_o is high.

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE and DONE, with one transaction in flight at most.
REQ-017 In IDLE with at least one reqN_valid_i high, SHALL assert reqN_ready_o for exactly one winner, latch its write, addr, wdata and id, and move to ISSUE.
REQ-018 reqN_ready_o SHALL be combinational and SHALL be low in ISSUE and DONE.
REQ-019 In ISSUE, SHALL drive mem_addr_o and mem_wdata_o from the latch and assert mem_read_o or mem_write_o for exactly one cycle, then move to DONE.
REQ-020 In ISSUE on a read, SHALL capture mem_rdata_i into a response register at the clock edge that ends the cycle.
REQ-021 In DONE, SHALL pulse rspN_valid_o only for the latched id, with rspN_rdata_o equal to the captured data on reads and 0 on writes, then move to IDLE.
REQ-022 Latency: acceptance in cycle T puts the strobe in T+1 and the response in T+2; the next acceptance is possible in T+3.
REQ-023 An address >= DEPTH SHALL suppress both memory strobes in ISSUE, and the response in DONE SHALL carry rspN_err_o=1 and rspN_rdata_o=0.
REQ-024 The losing requester SHALL keep its valid held without being accepted; no request SHALL be dropped or duplicated.
REQ-025 mem_read_o and mem_write_o SHALL never be high together, and both SHALL be low outside ISSUE.
REQ-026 A request that lowers valid before ready is high SHALL have no effect.

Reset
REQ-027 rst_i high at a clock edge SHALL force IDLE and clear the latches and response register, including mid-transaction.
REQ-028 After reset, all outputs SHALL be 0 and the priority pointer SHALL favour requester 0.
REQ-029 A response pending at reset SHALL be discarded, and no strobe SHALL appear in the cycle after the reset edge.

Configuration
REQ-030 Macro MEM_ARBITER_RR_EN defined: round-robin; when both requesters are valid, the one not granted last SHALL win, and the pointer SHALL update on each acceptance.
REQ-031 MEM_ARBITER_RR_EN undefined: fixed priority; requester 0 SHALL always win, and no pointer state SHALL exist.

Structure
REQ-032 Package mem_arbiter_pkg SHALL hold the FSM state enum, the requester-id type and the response-latency constant (2).
REQ-033 Winner selection SHALL be a sub-module named mem_arb_pick, with inputs 2 valids plus the pointer and outputs a one-hot grant plus the next pointer.

Verification
REQ-034 A single read from req0 at addr 3 with mem word 3 = 0xDEADBEEF SHALL give ready in T, mem_read_o in T+1, and rsp0_valid_o in T+2 with rdata 0xDEADBEEF.
REQ-035 req1 writing 0x12345678 to addr 5, then reading it back, SHALL give mem_write_o in one cycle only and a read returning 0x12345678.
REQ-036 With both valid continuously for 4 transactions under MEM_ARBITER_RR_EN, the grant order SHALL be 0,1,0,1; without the macro, it SHALL be 0,0,0,0.
REQ-037 req0 reading addr 8 SHALL produce no memory strobe and rsp0_valid_o=1 with err=1 and rdata=0.
REQ-038 rst_i asserted during ISSUE of a read SHALL produce no rsp pulse, state IDLE, all outputs 0 next cycle, and a req0 win on the next simultaneous request.
